// File: rtl/aes_encoder_pkg.sv
// Shared AES definitions: state layout, S-box, Rcon and the round primitives.
// The decoder imports the same package.
package AESDefinitions;

   typedef logic [7:0] byte_t;
   localparam int AES_STATE_SIZE = 16;
   // Byte 4c+r is row r, column c; byte 0 is the most significant byte.
   typedef byte_t [0:AES_STATE_SIZE-1] state_t;

   localparam byte_t [0:255] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam byte_t [0:9] RCON = 80'h01020408102040801b36;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic state_t SubBytes(input state_t s);
      state_t r;
      for (int i = 0; i < AES_STATE_SIZE; i++) r[i] = SBOX[s[i]];
      return r;
   endfunction

   function automatic state_t ShiftRows(input state_t s);
      state_t r;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[4*c + row] = s[4*((c + row) % 4) + row];
      return r;
   endfunction

   function automatic state_t MixColumns(input state_t s);
      state_t r;
      byte_t a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c + 1];
         a2 = s[4*c + 2];
         a3 = s[4*c + 3];
         r[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [31:0] RotWord(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] SubWord(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // keyBits holds the cipher key left-aligned; only words up to the requested round are built.
   function automatic state_t RoundKey(input logic [255:0] keyBits, input int nk, input int round);
      logic [31:0] w [0:59];
      logic [31:0] t;
      w = '{default: '0};
      t = '0;
      for (int i = 0; i < 4*round + 4; i++) begin
         if (i < nk) begin
            w[i] = keyBits[255 - 32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) t = SubWord(RotWord(t)) ^ {RCON[i/nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4) t = SubWord(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      return {w[4*round], w[4*round + 1], w[4*round + 2], w[4*round + 3]};
   endfunction

endpackage

// File: rtl/aes_encoder_if.sv
// Encoder data bus. No backpressure: a block is taken every clock, and valid
// qualifies encrypted (it is high once encrypted holds the result of a real sampled input).
interface aes_encoder_if
   import AESDefinitions::*;
#(
   parameter int KEY_SIZE = 128
);
   localparam int KEY_BYTES = KEY_SIZE / 8;

   state_t                   plainData;
   byte_t [0:KEY_BYTES-1]    key;
   state_t                   encrypted;
   logic                     valid;

   modport master (output plainData, key, input encrypted, valid);
   modport slave  (input plainData, key, output encrypted, valid);
endinterface

// File: rtl/aes_encoder_buffer.sv
// Generic register with asynchronous active-high clear.
module Buffer #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end
endmodule

// File: rtl/aes_encoder_round.sv
// One registered encryption stage; the round key is derived from the block's own cipher key.
module aes_encode_round
   import AESDefinitions::*;
#(
   parameter int KEY_SIZE = 128,
   parameter int ROUND    = 1,
   parameter bit FIRST    = 1'b0,
   parameter bit FINAL    = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  state_t              stateIn,
   input  logic [KEY_SIZE-1:0] keyIn,
   output state_t              stateOut,
   output logic [KEY_SIZE-1:0] keyOut
);
   localparam int NK = KEY_SIZE / 32;

   logic [255:0] keyBits;
   state_t       entered;
   state_t       mixed;
   state_t       nextState;

   always_comb begin
      keyBits = 256'(keyIn) << (256 - KEY_SIZE);
      entered = stateIn;
      if (FIRST) entered = stateIn ^ RoundKey(keyBits, NK, 0);
      mixed = ShiftRows(SubBytes(entered));
      if (!FINAL) mixed = MixColumns(mixed);
      nextState = mixed ^ RoundKey(keyBits, NK, ROUND);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateOut <= '0;
         keyOut   <= '0;
      end else begin
         stateOut <= nextState;
         keyOut   <= keyIn;
      end
   end
endmodule

// File: rtl/aes_encoder.sv
// Fully pipelined AES encryptor: one block per clock, NUM_ROUNDS clocks of latency.
module aes_encoder
   import AESDefinitions::*;
#(
   parameter int KEY_SIZE = 128
) (
   input  logic       clock,
   input  logic       reset,
   aes_encoder_if.slave bus
);
   localparam int NUM_ROUNDS = KEY_SIZE / 32 + 6;

   if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : gBadKeySize
      $fatal(1, "aes_encoder: KEY_SIZE must be 128, 192 or 256");
   end

   state_t              stageState [0:NUM_ROUNDS];
   logic [KEY_SIZE-1:0] stageKey   [0:NUM_ROUNDS];
   logic [NUM_ROUNDS-1:0] validChain;

   assign stageState[0] = bus.plainData;
   assign stageKey[0]   = bus.key;

   for (genvar g = 1; g <= NUM_ROUNDS; g++) begin : gRound
      aes_encode_round #(
         .KEY_SIZE (KEY_SIZE),
         .ROUND    (g),
         .FIRST    (g == 1),
         .FINAL    (g == NUM_ROUNDS)
      ) uRound (
         .clock    (clock),
         .reset    (reset),
         .stateIn  (stageState[g-1]),
         .keyIn    (stageKey[g-1]),
         .stateOut (stageState[g]),
         .keyOut   (stageKey[g])
      );
   end

   // A 1 enters every clock; the top bit marks that the pipe has filled since reset.
   Buffer #(.WIDTH(NUM_ROUNDS)) uValidChain (
      .clock (clock),
      .reset (reset),
      .d     ({validChain[NUM_ROUNDS-2:0], 1'b1}),
      .q     (validChain)
   );

   assign bus.encrypted = stageState[NUM_ROUNDS];
   assign bus.valid     = validChain[NUM_ROUNDS-1];
endmodule

// File: tb/tb_aes_encoder.sv
// Bench for aes_encoder: one instance per key size, streamed with known-answer vectors.
module tb_aes_encoder;
   import AESDefinitions::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int           ks;
      logic [255:0] key;
      state_t       pt;
      state_t       ct;
   } vec_t;
   vec_t tbl [$];

   task automatic addVec(input int ks, input logic [255:0] key, input logic [127:0] pt,
                         input logic [127:0] ct);
      vec_t v;
      v.ks  = ks;
      v.key = key;
      v.pt  = pt;
      v.ct  = ct;
      tbl.push_back(v);
   endtask

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gSize
      localparam int KS = 128 + 64*g;
      localparam int NR = KS/32 + 6;

      aes_encoder_if #(.KEY_SIZE(KS)) bus ();
      aes_encoder #(.KEY_SIZE(KS)) dut (
         .clock (clock),
         .reset (reset),
         .bus   (bus)
      );

      logic [128:0] exp_q [$];
      int idx = 0;
      int samples = 0;
      int pending = 0;

      // Monitor first (pops results of earlier edges), then drive the next sampled input.
      always @(negedge clock) begin
         logic [128:0] e;
         if (reset) begin
            checkVal($sformatf("ks%0d reset encrypted", KS), bus.encrypted, '0);
            checkVal($sformatf("ks%0d reset valid", KS), {127'b0, bus.valid}, '0);
            foreach (exp_q[k]) if (exp_q[k][128]) pending--;
            exp_q.delete();
            samples = 0;
            idx = 0;
         end else begin
            checkVal($sformatf("ks%0d valid after %0d samples", KS, samples),
                     {127'b0, bus.valid}, {127'b0, samples >= NR});
            if (bus.valid) begin
               if (exp_q.size() == 0) begin
                  checkVal($sformatf("ks%0d output with empty queue", KS), 128'd1, 128'd0);
               end else begin
                  e = exp_q.pop_front();
                  if (e[128]) begin
                     checkVal($sformatf("ks%0d ciphertext", KS), bus.encrypted, e[127:0]);
                     pending--;
                  end
               end
            end
            while (idx < tbl.size() && tbl[idx].ks != KS) idx++;
            if (idx < tbl.size()) begin
               bus.plainData = tbl[idx].pt;
               bus.key       = tbl[idx].key[255 -: KS];
               exp_q.push_back({1'b1, tbl[idx].ct});
               pending++;
               idx++;
            end else begin
               bus.plainData = '0;
               bus.key       = '0;
               exp_q.push_back({1'b0, 128'h0});
            end
            samples++;
         end
      end
   end

   localparam logic [255:0] KEY_A128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_B128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY_A192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_B192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY_A256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_B256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT_38A1  = 128'h6bc1bee22e409f96e93d7e117393172a;

   initial begin
      addVec(128, KEY_A128, PT_FIPS, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      addVec(128, KEY_B128, PT_38A1, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
      addVec(128, '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      addVec(128, KEY_B128, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf);
      addVec(128, KEY_A128, PT_FIPS, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      addVec(128, KEY_B128, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688);
      addVec(128, '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      addVec(128, KEY_B128, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4);
      addVec(128, KEY_B128, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
      addVec(192, KEY_A192, PT_FIPS, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      addVec(192, KEY_B192, PT_38A1, 128'hbd334f1d6e45f25ff712a214571fa5cc);
      addVec(192, KEY_A192, PT_FIPS, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      addVec(256, KEY_A256, PT_FIPS, 128'h8ea2b7ca516745bfeafc49904b496089);
      addVec(256, KEY_B256, PT_38A1, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8);
      addVec(256, KEY_A256, PT_FIPS, 128'h8ea2b7ca516745bfeafc49904b496089);

      // Initial reset, then stream every vector back-to-back and drain.
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      repeat (40) @(posedge clock);

      // Reset with the pipes full and valid high; release refeeds the vectors.
      #2 reset = 1'b1;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      repeat (12) @(posedge clock);

      // Reset while real blocks are in flight; they must be dropped.
      #2 reset = 1'b1;
      @(posedge clock);
      #2 reset = 1'b0;
      repeat (40) @(posedge clock);
      @(negedge clock);
      #1;

      checkVal("ks128 unchecked vectors left", 128'(gSize[0].pending), '0);
      checkVal("ks192 unchecked vectors left", 128'(gSize[1].pending), '0);
      checkVal("ks256 unchecked vectors left", 128'(gSize[2].pending), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
